max_client_driver: RTL and testbench
====================================

// Module: max_client_driver
// PURPOSE
//   Client-side master for the pipelined max engine. Buffers words from an upstream producer and
//   issues them to the engine in groups of GROUP words over client_val/client_rdy. It then drives
//   max_rdy, captures max_data on max_val and returns it upstream on a res_val/res_rdy port.
//   Sits between the host stream and the max engine; one group is in flight at a time.
// PARAMETERS
//   DATA_W     8    width of data words and of the result
//   GROUP      4    words per max group; power of two, 2..16
//   FIFO_DEPTH 8    input FIFO entries; power of two, >= GROUP
//   TIMEOUT    64   max cycles in WAIT_RES before error; >= 2
// PORTS
//   clk          in   1        clock, rising edge
//   rst_n        in   1        reset, asynchronous, active-low
//   in_val       in   1        upstream word valid
//   in_rdy       out  1        FIFO not full
//   in_data      in   DATA_W   upstream word
//   client_val   out  1        word offered to the engine
//   client_rdy   in   1        engine accepts the word
//   client_data  out  DATA_W   word to the engine
//   max_val      in   1        engine result valid
//   max_rdy      out  1        driver ready for the result
//   max_data     in   DATA_W   engine result
//   res_val      out  1        captured result valid
//   res_rdy      in   1        upstream consumes the result
//   res_data     out  DATA_W   captured max of the group
//   timeout_err  out  1        one-cycle pulse: result never arrived
// BEHAVIOUR
//   - Handshakes: a transfer occurs on the edge where val&&rdy is high. A val, once raised, holds
//     with stable data until it transfers.
//   - Reset values: in_rdy=0 during reset, then 1. client_val=0, max_rdy=0, res_val=0,
//     res_data=0, timeout_err=0. FIFO empty, state IDLE, counters 0.
//   - Reset asserted mid-operation aborts the group with no result. The FIFO contents are lost.
//   - FIFO: in_rdy = !full. A write and a read in the same cycle when full is not allowed
//     (in_rdy=0). A write and a read in the same cycle when empty is not a bypass: the word
//     appears the next cycle. Pointers wrap modulo FIFO_DEPTH.
//   - FSM:
//     IDLE -> SEND when FIFO count >= GROUP and res_val==0.
//     SEND: client_val=1 and client_data=FIFO head (registered output). Each transfer pops the
//       FIFO and increments snt. On the transfer with snt==GROUP-1, go to WAIT_RES.
//       The FIFO is never empty in SEND, because GROUP words were present at entry.
//     WAIT_RES: max_rdy=1 and tmo increments each cycle.
//       On max_val: res_data<=max_data, res_val<=1, go to IDLE.
//       Else if tmo==TIMEOUT-1: timeout_err=1 for one cycle, go to IDLE, no result.
//     Back-to-back groups: IDLE waits only for res_val clearing. If res_rdy is high in the
//       capture cycle+1, the next SEND starts 2 cycles after capture.
//   - Result: res_val holds until res_val&&res_rdy, then clears; res_data stays unchanged.
//   - Latency: in_data to client_data is >= 2 cycles (FIFO write, then registered head).
//   - Counters: snt is clog2(GROUP) bits and tmo is clog2(TIMEOUT) bits. Both clear on entry to
//     SEND and to WAIT_RES respectively. No arithmetic on data; max_data is passed unmodified.
//   - max_val outside WAIT_RES is ignored (max_rdy=0).
//   - A timeout with max_val in the same cycle: the capture wins and there is no error.
// STRUCTURE
//   - Package max_if_pkg: typedef enum {IDLE, SEND, WAIT_RES} drv_state_t, plus DATA_W_DEF=8 and
//     GROUP_DEF=4 shared with the engine.
//   - Sub-module sync_fifo (DATA_W, DEPTH), instanced once for the input buffer.
//     FSM, counters and result register live in this module.
// TESTING
//   1. Reset, then push 3,9,1,7. Expect client_data 3,9,1,7 on 4 transfers, then max_rdy=1.
//      Engine returns 9: res_val=1, res_data=9 one cycle after max_val.
//   2. client_rdy toggles 1/0 during SEND. Expect client_val held, client_data stable while
//      stalled, and no word dropped or duplicated.
//   3. Push 8 words (two groups), hold res_rdy=0. Expect the second SEND not to start until
//      res_rdy pulses. Expect in_rdy=0 when the FIFO holds 8.
//   4. Never assert max_val. Expect a timeout_err pulse exactly TIMEOUT=64 cycles after entering
//      WAIT_RES, return to IDLE, and res_val=0.
//   5. Assert rst_n=0 after 2 words are sent. Expect all outputs at reset values and the FIFO
//      empty. A new group of 0xFF,0x00,0x80,0x7F afterwards gives res_data=0xFF.
//   6. Assert max_val in the same cycle tmo==63. Expect the capture, no timeout_err, and
//      res_data equal to max_data.

Source files
------------

// File: rtl/max_if_pkg.sv
// Shared definitions for the max engine and its client driver.
//   DATA_W_DEF / GROUP_DEF : default word width and group size used by both sides
//   drv_state_t            : client driver FSM states
package max_if_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int GROUP_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_RES = 2'd2
  } drv_state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with no read bypass: a word written while empty is
// visible at the head on the following cycle.
// Ports:
//   clk, rst_n          clock / async active-low reset (pointers and count only)
//   wr_en, wr_data      write request; ignored while full
//   rd_en               pop request; ignored while empty
//   rd_data             current head word
//   rd_data_nxt         word behind the head (valid when count >= 2)
//   count, full, empty  occupancy
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] rd_data_nxt,
  output logic [AW:0]       count,
  output logic              full,
  output logic              empty
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic              wr_ok, rd_ok;

  assign full        = (cnt_q == (AW+1)'(DEPTH));
  assign empty       = (cnt_q == '0);
  assign count       = cnt_q;
  assign wr_ok       = wr_en && !full;
  assign rd_ok       = rd_en && !empty;
  assign rd_data     = mem_q[rd_ptr_q];
  // Pointers are exactly AW bits wide, so +1 wraps modulo DEPTH.
  assign rd_data_nxt = mem_q[rd_ptr_q + AW'(1)];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_ok) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/max_client_driver.sv
// Client-side master for the pipelined max engine. Buffers upstream words,
// sends them to the engine in groups of GROUP, waits for the engine result
// and hands it upstream. One group in flight at a time.
// Ports:
//   clk, rst_n                          clock / async active-low reset
//   in_val, in_rdy, in_data             upstream word stream into the FIFO
//   client_val, client_rdy, client_data words offered to the engine
//   max_val, max_rdy, max_data          engine result
//   res_val, res_rdy, res_data          captured group max returned upstream
//   timeout_err                         one-cycle pulse when no result arrived
module max_client_driver
  import max_if_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int GROUP      = GROUP_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_val,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] in_data,
  output logic              client_val,
  input  logic              client_rdy,
  output logic [DATA_W-1:0] client_data,
  input  logic              max_val,
  output logic              max_rdy,
  input  logic [DATA_W-1:0] max_data,
  output logic              res_val,
  input  logic              res_rdy,
  output logic [DATA_W-1:0] res_data,
  output logic              timeout_err
);
  localparam int SNT_W = $clog2(GROUP);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [SNT_W-1:0] SNT_LAST  = SNT_W'(GROUP - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GROUP_CNT = CNT_W'(GROUP);

  drv_state_t        state_q, state_d;
  logic [SNT_W-1:0]  snt_q, snt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              client_val_q, client_val_d;
  logic [DATA_W-1:0] client_data_q, client_data_d;
  logic              max_rdy_q, max_rdy_d;
  logic              res_val_q, res_val_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;
  logic              timeout_err_q, timeout_err_d;
  // Holds in_rdy low while in reset and for the first edge after it.
  logic              alive_q;

  logic [DATA_W-1:0] fifo_head, fifo_head_nxt;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic              pop;

  assign in_rdy = alive_q && !fifo_full;
  assign pop    = (state_q == SEND) && client_val_q && client_rdy;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (in_val && in_rdy),
    .wr_data     (in_data),
    .rd_en       (pop),
    .rd_data     (fifo_head),
    .rd_data_nxt (fifo_head_nxt),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty)
  );

  always_comb begin
    state_d       = state_q;
    snt_d         = snt_q;
    tmo_d         = tmo_q;
    client_val_d  = client_val_q;
    client_data_d = client_data_q;
    max_rdy_d     = max_rdy_q;
    res_val_d     = res_val_q;
    res_data_d    = res_data_q;
    timeout_err_d = 1'b0;

    if (res_val_q && res_rdy) res_val_d = 1'b0;

    case (state_q)
      IDLE: begin
        // A pending result blocks the next group so results never overwrite.
        if (fifo_count >= GROUP_CNT && !res_val_q) begin
          state_d       = SEND;
          client_val_d  = 1'b1;
          client_data_d = fifo_head;
          snt_d         = '0;
        end
      end
      SEND: begin
        if (pop) begin
          if (snt_q == SNT_LAST) begin
            state_d      = WAIT_RES;
            client_val_d = 1'b0;
            max_rdy_d    = 1'b1;
            tmo_d        = '0;
          end else begin
            // Head is being popped this edge, so the next word is the one behind it.
            snt_d         = snt_q + SNT_W'(1);
            client_data_d = fifo_head_nxt;
          end
        end
      end
      WAIT_RES: begin
        // Capture takes priority over an expiring timeout.
        if (max_val) begin
          res_data_d = max_data;
          res_val_d  = 1'b1;
          max_rdy_d  = 1'b0;
          state_d    = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          timeout_err_d = 1'b1;
          max_rdy_d     = 1'b0;
          state_d       = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      default: begin
        state_d      = IDLE;
        client_val_d = 1'b0;
        max_rdy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      snt_q         <= '0;
      tmo_q         <= '0;
      client_val_q  <= 1'b0;
      client_data_q <= '0;
      max_rdy_q     <= 1'b0;
      res_val_q     <= 1'b0;
      res_data_q    <= '0;
      timeout_err_q <= 1'b0;
      alive_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      snt_q         <= snt_d;
      tmo_q         <= tmo_d;
      client_val_q  <= client_val_d;
      client_data_q <= client_data_d;
      max_rdy_q     <= max_rdy_d;
      res_val_q     <= res_val_d;
      res_data_q    <= res_data_d;
      timeout_err_q <= timeout_err_d;
      alive_q       <= 1'b1;
    end
  end

  assign client_val  = client_val_q;
  assign client_data = client_data_q;
  assign max_rdy     = max_rdy_q;
  assign res_val     = res_val_q;
  assign res_data    = res_data_q;
  assign timeout_err = timeout_err_q;
endmodule

// File: tb/tb_max_client_driver.sv
// Randomized bench for max_client_driver: an order-preserving word queue and a
// group-max computed from it act as the reference; the bench plays both the
// upstream producer/consumer and the max engine.
module tb_max_client_driver;
  localparam int DW = 8, GROUP = 4, DEPTH = 8, TIMEOUT = 64;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_val = 1'b0, in_rdy;
  logic [DW-1:0] in_data = '0;
  logic          client_val, client_rdy = 1'b0;
  logic [DW-1:0] client_data;
  logic          max_val = 1'b0, max_rdy;
  logic [DW-1:0] max_data = '0;
  logic          res_val, res_rdy = 1'b0;
  logic [DW-1:0] res_data;
  logic          timeout_err;

  max_client_driver #(.DATA_W(DW), .GROUP(GROUP), .FIFO_DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .client_val(client_val), .client_rdy(client_rdy), .client_data(client_data),
    .max_val(max_val), .max_rdy(max_rdy), .max_data(max_data),
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [DW-1:0] model_q[$];   // words accepted upstream, oldest first
  logic [DW-1:0] grp_exp[$];   // reference words of the group just sent
  logic [DW-1:0] got_w[$];     // words the engine side actually received
  logic [DW-1:0] last_max;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [DW-1:0] w);
    int n = 0;
    in_val = 1'b1; in_data = w;
    while (!in_rdy && n < 200) begin tick(); n++; end
    if (!in_rdy) check("push_stuck", 0, 1);
    else model_q.push_back(w);
    tick();
    in_val = 1'b0;
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) push(DW'($urandom));
  endtask

  task automatic recv(input int n, input bit stall);
    int guard = 0;
    bit was_stalled = 1'b0;
    logic [DW-1:0] held = '0;
    got_w.delete(); grp_exp.delete();
    while (got_w.size() < n && guard < 400) begin
      client_rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (was_stalled) begin
        check("stall_val", 32'(client_val), 1);
        check("stall_data", 32'(client_data), 32'(held));
      end
      if (client_val && client_rdy) begin
        got_w.push_back(client_data);
        if (model_q.size() > 0) begin
          grp_exp.push_back(model_q[0]);
          check("client_data", 32'(client_data), 32'(model_q.pop_front()));
        end else check("client_extra", 1, 0);
      end
      was_stalled = client_val && !client_rdy;
      held = client_data;
      tick();
      guard++;
    end
    client_rdy = 1'b0;
    if (got_w.size() != n) check("recv_count", 32'(got_w.size()), 32'(n));
  endtask

  function automatic logic [DW-1:0] qmax(input logic [DW-1:0] q[$]);
    logic [DW-1:0] m = '0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  // Engine: returns the max of what it received after dly cycles.
  task automatic engine(input int dly);
    int g = 0;
    while (!max_rdy && g < 50) begin tick(); g++; end
    check("max_rdy", 32'(max_rdy), 1);
    repeat (dly) tick();
    max_val = 1'b1; max_data = qmax(got_w);
    tick();
    max_val = 1'b0; max_data = DW'($urandom);
    last_max = qmax(grp_exp);
    check("res_val", 32'(res_val), 1);
    check("res_data", 32'(res_data), 32'(last_max));
  endtask

  task automatic consume(input int dly);
    repeat (dly) tick();
    check("res_hold", 32'(res_val), 1);
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    check("res_clear", 32'(res_val), 0);
    check("res_keep", 32'(res_data), 32'(last_max));
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_in_rdy"}, 32'(in_rdy), 0);
    check({tag, "_client_val"}, 32'(client_val), 0);
    check({tag, "_max_rdy"}, 32'(max_rdy), 0);
    check({tag, "_res_val"}, 32'(res_val), 0);
    check({tag, "_res_data"}, 32'(res_data), 0);
    check({tag, "_tmo_err"}, 32'(timeout_err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    logic [DW-1:0] r;
    logic [DW-1:0] t1 [4];
    logic [DW-1:0] t5 [4];
    t1 = '{8'd3, 8'd9, 8'd1, 8'd7};
    t5 = '{8'hFF, 8'h00, 8'h80, 8'h7F};

    // Reset state
    repeat (3) @(negedge clk);
    check_reset_outs("rst");
    rst_n = 1'b1;
    tick(); tick();
    check("in_rdy_up", 32'(in_rdy), 1);

    // Directed group 3,9,1,7
    foreach (t1[i]) push(t1[i]);
    recv(4, 1'b0);
    check("t1_max_rdy", 32'(max_rdy), 1);
    check("t1_client_val", 32'(client_val), 0);
    max_val = 1'b1; max_data = 8'd9; tick(); max_val = 1'b0;
    last_max = 8'd9;
    check("t1_res_val", 32'(res_val), 1);
    check("t1_res_data", 32'(res_data), 9);
    consume(1);

    // Random groups with engine-side stalls
    for (int g = 0; g < 4; g++) begin
      push_rand(GROUP);
      recv(GROUP, 1'b1);
      engine($urandom_range(0, 5));
      consume($urandom_range(0, 3));
    end

    // Pending result blocks the next group; FIFO fills to capacity
    push_rand(GROUP); recv(GROUP, 1'b0); engine(1);
    push_rand(DEPTH);
    check("full_in_rdy", 32'(in_rdy), 0);
    first = 0;
    repeat (6) begin tick(); if (client_val) first++; end
    check("blocked_send", 32'(first), 0);
    consume(0);
    recv(GROUP, 1'b1);
    engine(2);
    // Result consumed the cycle after capture: next SEND two cycles after capture
    res_rdy = 1'b1; tick(); res_rdy = 1'b0;
    check("b2b_res_clear", 32'(res_val), 0);
    check("b2b_not_yet", 32'(client_val), 0);
    tick();
    check("b2b_send", 32'(client_val), 1);
    recv(GROUP, 1'b0); engine(0); consume(0);

    // Timeout: no engine answer
    push_rand(GROUP); recv(GROUP, 1'b0);
    first = -1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (timeout_err) begin first = i; break; end
    end
    check("tmo_cycle", 32'(first), 64);
    check("tmo_max_rdy", 32'(max_rdy), 0);
    check("tmo_res_val", 32'(res_val), 0);
    tick();
    check("tmo_pulse", 32'(timeout_err), 0);

    // Result arriving on the last timeout cycle wins
    push_rand(GROUP); recv(GROUP, 1'b0);
    repeat (TIMEOUT - 1) tick();
    check("late_max_rdy", 32'(max_rdy), 1);
    r = DW'($urandom);
    max_val = 1'b1; max_data = r; tick(); max_val = 1'b0;
    last_max = r;
    check("late_tmo_err", 32'(timeout_err), 0);
    check("late_res_val", 32'(res_val), 1);
    check("late_res_data", 32'(res_data), 32'(r));
    tick();
    check("late_tmo_err2", 32'(timeout_err), 0);
    consume(0);

    // Reset mid-group
    push_rand(GROUP); recv(2, 1'b0);
    @(negedge clk); rst_n = 1'b0;
    model_q.delete();
    #2;
    check_reset_outs("mid");
    @(negedge clk); rst_n = 1'b1;
    tick(); tick();
    // Engine result outside WAIT_RES must be ignored
    max_val = 1'b1; max_data = 8'h55; tick(); max_val = 1'b0;
    check("stray_max", 32'(res_val), 0);
    check("empty_after_rst", 32'(client_val), 0);
    foreach (t5[i]) push(t5[i]);
    recv(4, 1'b1);
    engine(3);
    check("t5_res_data", 32'(res_data), 32'hFF);
    consume(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
